hdr_sched: RTL and testbench



---
 rtl/hdr_sched.sv | 211 +++++++++++++++++++++
 tb/tb_hdr_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_sched.sv
// Round-robin scheduler sharing one header analysis unit between NUM_REQ block producers.
// Define HDR_SCHED_STATS_EN to add the stat_blocks / stat_compressable handshake counters.
module hdr_sched #(
   parameter int NUM_REQ = 4,
   parameter int HDR_LAT = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0][31:0][3:0][7:0]   req_pixels,
   output logic [31:0][3:0][7:0]                hdr_pixels,
   input  logic                                 hdr_compressable,
   input  logic [47:0]                          hdr_header,
   output logic                                 res_valid,
   input  logic                                 res_ready,
   output logic [ID_W-1:0]                      res_id,
   output logic                                 res_compressable,
   output logic [47:0]                          res_header,
   output logic                                 busy
`ifdef HDR_SCHED_STATS_EN
   ,
   output logic [31:0]                          stat_blocks,
   output logic [31:0]                          stat_compressable
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   localparam int CNT_W = 4;

   state_e                   state_q, state_d;
   logic [31:0][3:0][7:0]    hold_q, hold_d;
   logic [ID_W-1:0]          id_q, id_d;
   logic [ID_W-1:0]          last_grant_q, last_grant_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     res_valid_q, res_valid_d;
   logic [ID_W-1:0]          res_id_q, res_id_d;
   logic                     res_cmp_q, res_cmp_d;
   logic [47:0]              res_header_q, res_header_d;

   logic [ID_W-1:0]          grant;
   logic                     grant_vld;
   logic [ID_W-1:0]          cand;
   logic                     is_idle;
   logic                     accept;

   // Walk from the farthest candidate back to last_grant+1 so the nearest valid one wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
         if (req_valid[cand]) begin
            grant     = cand;
            grant_vld = 1'b1;
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      is_idle = (state_q == ST_IDLE);
      busy    = !is_idle;
      accept  = is_idle && grant_vld;
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant == ID_W'(gi));
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      hold_d       = hold_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      res_valid_d  = res_valid_q;
      res_id_d     = res_id_q;
      res_cmp_d    = res_cmp_q;
      res_header_d = res_header_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               hold_d       = req_pixels[grant];
               id_d         = grant;
               last_grant_d = grant;
               cnt_d        = CNT_W'(HDR_LAT);
            end
         end
         ST_WAIT: begin
            // The header unit has now seen the held block for HDR_LAT full cycles.
            if (cnt_q == CNT_W'(1)) begin
               res_cmp_d    = hdr_compressable;
               res_header_d = hdr_header;
               res_id_d     = id_q;
               res_valid_d  = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q       <= '0;
         id_q         <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         cnt_q        <= '0;
         res_valid_q  <= 1'b0;
         res_id_q     <= '0;
         res_cmp_q    <= 1'b0;
         res_header_q <= '0;
      end else begin
         hold_q       <= hold_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         res_valid_q  <= res_valid_d;
         res_id_q     <= res_id_d;
         res_cmp_q    <= res_cmp_d;
         res_header_q <= res_header_d;
      end
   end

   assign hdr_pixels       = hold_q;
   assign res_valid        = res_valid_q;
   assign res_id           = res_id_q;
   assign res_compressable = res_cmp_q;
   assign res_header       = res_header_q;

`ifdef HDR_SCHED_STATS_EN
   logic [31:0] stat_blocks_q, stat_blocks_d;
   logic [31:0] stat_cmp_q, stat_cmp_d;
   logic        res_hs;

   // Counted at the result handshake, so a result stalled in OUT is not yet included.
   always_comb begin
      res_hs        = res_valid_q && res_ready;
      stat_blocks_d = stat_blocks_q;
      stat_cmp_d    = stat_cmp_q;
      if (res_hs && (stat_blocks_q != 32'hFFFF_FFFF)) begin
         stat_blocks_d = stat_blocks_q + 32'd1;
      end
      if (res_hs && res_cmp_q && (stat_cmp_q != 32'hFFFF_FFFF)) begin
         stat_cmp_d = stat_cmp_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_blocks_q <= '0;
         stat_cmp_q    <= '0;
      end else begin
         stat_blocks_q <= stat_blocks_d;
         stat_cmp_q    <= stat_cmp_d;
      end
   end

   assign stat_blocks       = stat_blocks_q;
   assign stat_compressable = stat_cmp_q;
`endif

endmodule

// File: tb/tb_hdr_sched.sv
// Self-checking bench for hdr_sched: arbitration table, latency, backpressure, reset mid-WAIT.
// With HDR_SCHED_STATS_EN defined the handshake counters are checked as well.
module tb_hdr_sched;

   localparam int NUM_REQ = 4;
   localparam int HDR_LAT = 2;
   localparam int ID_W    = 2;

   logic                               clk = 1'b0;
   logic                               rst;
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ-1:0][31:0][3:0][7:0] req_pixels;
   logic [31:0][3:0][7:0]              hdr_pixels;
   logic                               hdr_compressable;
   logic [47:0]                        hdr_header;
   logic                               res_valid;
   logic                               res_ready;
   logic [ID_W-1:0]                    res_id;
   logic                               res_compressable;
   logic [47:0]                        res_header;
   logic                               busy;
`ifdef HDR_SCHED_STATS_EN
   logic [31:0]                        stat_blocks;
   logic [31:0]                        stat_compressable;
`endif

   always #5 clk = ~clk;

   hdr_sched #(.NUM_REQ(NUM_REQ), .HDR_LAT(HDR_LAT), .ID_W(ID_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_pixels       (req_pixels),
      .hdr_pixels       (hdr_pixels),
      .hdr_compressable (hdr_compressable),
      .hdr_header       (hdr_header),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_id           (res_id),
      .res_compressable (res_compressable),
      .res_header       (res_header),
      .busy             (busy)
`ifdef HDR_SCHED_STATS_EN
      ,
      .stat_blocks      (stat_blocks),
      .stat_compressable(stat_compressable)
`endif
   );

   // Header unit model: returns a garbage answer until its inputs have been stable HDR_LAT cycles.
   logic [31:0][3:0][7:0] prev_pix = '0;
   logic [7:0]            age = '0;
   logic                  mdl_ready;
   logic [31:0]           mdl_pix0;
   bit                    use_fn = 1'b0;
   logic [47:0]           hdr_val = '0;
   logic                  hdr_cmp = 1'b0;

   always @(posedge clk) begin
      if (hdr_pixels != prev_pix) age <= 8'd1;
      else if (age != 8'hFF)      age <= age + 8'd1;
      prev_pix <= hdr_pixels;
   end

   always_comb begin
      mdl_pix0  = hdr_pixels[0];
      mdl_ready = (hdr_pixels == prev_pix) ? ((32'(age) + 1) >= HDR_LAT) : (HDR_LAT <= 1);
      if (mdl_ready) begin
         hdr_header       = use_fn ? {16'h5A5A, mdl_pix0} : hdr_val;
         hdr_compressable = use_fn ? mdl_pix0[0] : hdr_cmp;
      end else begin
         hdr_header       = 48'hBAD0_BAD0_BAD0;
         hdr_compressable = use_fn ? !mdl_pix0[0] : !hdr_cmp;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   int seq   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pix0_of(input int r, input int s, input bit c);
      return {8'(8'hA0 + r), 8'(s), 15'h0AB5, c};
   endfunction

   function automatic int oh2i(input logic [3:0] v);
      int k = -1;
      for (int i = 0; i < 4; i++) if (v[i]) k = i;
      return k;
   endfunction

   task automatic set_pixels(input bit cbit);
      for (int r = 0; r < NUM_REQ; r++) begin
         req_pixels[r][0] = pix0_of(r, seq, cbit);
         for (int p = 1; p < 32; p++) req_pixels[r][p] = {8'(r), 8'(p), 8'(seq), 8'h77};
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge with the DUT idle; runs one full grant/result exchange with res_ready=1.
   task automatic do_txn(input string name, input logic [3:0] mask, input logic [3:0] exp_rdy,
                         input bit cbit);
      int n;
      int e_id;
      seq++;
      use_fn = 1'b1;
      set_pixels(cbit);
      req_valid = mask;
      #1;
      chk({name, " ready"}, req_ready, exp_rdy);
      if (exp_rdy == 4'b0000) begin
         @(negedge clk);
         chk({name, " idle busy"}, busy, 0);
         req_valid = '0;
         $display("txn %s: no grant", name);
         return;
      end
      e_id = oh2i(exp_rdy);
      @(negedge clk);
      chk({name, " ready after accept"}, req_ready, 0);
      req_valid = '0;
      n = 1;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, " latency"}, n, HDR_LAT + 1);
      chk({name, " res_id"}, res_id, e_id);
      chk({name, " res_header"}, res_header, {16'h5A5A, pix0_of(e_id, seq, cbit)});
      chk({name, " res_cmp"}, res_compressable, cbit);
      $display("txn %s: id=%0d header=%h cmp=%0d", name, res_id, res_header, res_compressable);
      n = 0;
      while (res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, " back to idle"}, busy, 0);
   endtask

   typedef struct {
      logic [3:0] mask;
      logic [3:0] exp_rdy;
      bit         cbit;
   } vec_t;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[11];
      int   n;
      int   g_cnt;
      int   r_cnt;
      int   exp_g[5];
      logic [47:0] held_hdr;
      bit   rose;

      vecs[0]  = '{4'b1111, 4'b0001, 1'b1};
      vecs[1]  = '{4'b1111, 4'b0010, 1'b0};
      vecs[2]  = '{4'b0110, 4'b0100, 1'b1};
      vecs[3]  = '{4'b1001, 4'b1000, 1'b0};   // last_grant=2, only 0 and 3: wrap/skip
      vecs[4]  = '{4'b1001, 4'b0001, 1'b1};
      vecs[5]  = '{4'b0000, 4'b0000, 1'b0};
      vecs[6]  = '{4'b0010, 4'b0010, 1'b1};
      vecs[7]  = '{4'b0010, 4'b0010, 1'b0};
      vecs[8]  = '{4'b1100, 4'b0100, 1'b1};
      vecs[9]  = '{4'b1010, 4'b1000, 1'b0};
      vecs[10] = '{4'b0011, 4'b0001, 1'b1};
      exp_g    = '{0, 1, 2, 3, 0};

      req_pixels = '0;
      do_reset();

      // Reset state
      #1;
      chk("rst res_valid", res_valid, 0);
      chk("rst req_ready", req_ready, 0);
      chk("rst busy", busy, 0);
      chk("rst res_id", res_id, 0);
      chk("rst res_header", res_header, 0);
      chk("rst res_cmp", res_compressable, 0);
      chk("rst hdr_pixels zero", hdr_pixels == '0, 1);

      // Single requester, fixed header answer
      use_fn  = 1'b0;
      hdr_val = 48'hABCD_0000_1234;
      hdr_cmp = 1'b1;
      req_pixels[1][0] = 32'h1122_3344;
      req_valid = 4'b0010;
      #1;
      chk("single ready", req_ready, 4'b0010);
      @(negedge clk);
      chk("single ready 1 cycle", req_ready, 0);
      chk("single hdr_pixels", hdr_pixels[0], 32'h1122_3344);
      req_valid = '0;
      n = 1;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("single latency", n, 3);
      chk("single res_id", res_id, 1);
      chk("single res_header", res_header, 48'hABCD_0000_1234);
      chk("single res_cmp", res_compressable, 1);
      $display("txn single: id=%0d header=%h cmp=%0d", res_id, res_header, res_compressable);
      @(negedge clk);
      chk("single res_valid drop", res_valid, 0);

      // All four requesters valid continuously
      do_reset();
      seq++;
      use_fn = 1'b1;
      set_pixels(1'b0);
      req_valid = 4'b1111;
      g_cnt = 0;
      r_cnt = 0;
      for (int t = 0; t < 18; t++) begin
         if (t == 0) #1;
         else @(negedge clk);
         chk("rr onehot", $countones(req_ready) <= 1, 1);
         if (req_ready != 4'b0000 && g_cnt < 5) begin
            chk("rr grant id", oh2i(req_ready), exp_g[g_cnt]);
            chk("rr grant time", t, 4 * g_cnt);
            $display("txn rr grant: id=%0d at cycle %0d", oh2i(req_ready), t);
            g_cnt++;
         end
         if (res_valid && r_cnt < 4) begin
            chk("rr res_id", res_id, r_cnt);
            chk("rr res time", t, 4 * r_cnt + HDR_LAT + 1);
            chk("rr res_header", res_header, {16'h5A5A, pix0_of(r_cnt, seq, 1'b0)});
            $display("txn rr result: id=%0d header=%h", res_id, res_header);
            r_cnt++;
         end
      end
      chk("rr grant count", g_cnt, 5);
      chk("rr result count", r_cnt, 4);
      req_valid = '0;
      n = 0;
      while ((busy || res_valid) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rr drain", busy, 0);

      // Backpressure: grant 2, hold the result 10 cycles while the header answer moves
      seq++;
      set_pixels(1'b1);
      use_fn    = 1'b0;
      hdr_val   = 48'h0123_4567_89AB;
      hdr_cmp   = 1'b1;
      res_ready = 1'b0;
      req_valid = 4'b0100;
      #1;
      chk("bp ready", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = 4'b1111;
      n = 1;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp latency", n, HDR_LAT + 1);
      held_hdr = 48'h0123_4567_89AB;
      for (int k = 0; k < 10; k++) begin
         hdr_val = {16'(k), 32'($urandom)};
         hdr_cmp = !hdr_cmp;
         @(negedge clk);
         chk("bp res_valid", res_valid, 1);
         chk("bp res_header", res_header, held_hdr);
         chk("bp res_cmp", res_compressable, 1);
         chk("bp res_id", res_id, 2);
         chk("bp req_ready", req_ready, 0);
         chk("bp busy", busy, 1);
      end
      $display("txn backpressure: id=%0d header=%h held 10 cycles", res_id, res_header);
      res_ready = 1'b1;
      @(negedge clk);
      chk("bp release res_valid", res_valid, 0);
      chk("bp release next grant", req_ready, 4'b1000);
      req_valid = '0;
      hdr_cmp   = 1'b0;
      @(negedge clk);
      chk("bp no accept busy", busy, 0);

      // Reset at counter==1 after granting requester 2
      seq++;
      set_pixels(1'b0);
      use_fn    = 1'b1;
      req_valid = 4'b0100;
      #1;
      chk("rw ready", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      chk("rw res_valid before rst", res_valid, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rw res_valid", res_valid, 0);
      chk("rw res_id", res_id, 0);
      chk("rw res_header", res_header, 0);
      chk("rw res_cmp", res_compressable, 0);
      chk("rw req_ready", req_ready, 0);
      chk("rw busy", busy, 0);
      chk("rw hdr_pixels zero", hdr_pixels == '0, 1);
      rose = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (res_valid) rose = 1'b1;
      end
      chk("rw no result", rose, 0);
      $display("txn reset-mid-wait: block discarded");
      do_txn("rw next", 4'b1101, 4'b0001, 1'b1);

      // Arbitration table from a fresh reset
      do_reset();
      for (int i = 0; i < 11; i++) begin
         do_txn($sformatf("v%0d", i), vecs[i].mask, vecs[i].exp_rdy, vecs[i].cbit);
      end

`ifdef HDR_SCHED_STATS_EN
      do_reset();
      #1;
      chk("st rst blocks", stat_blocks, 0);
      chk("st rst cmp", stat_compressable, 0);
      do_txn("st0", 4'b0001, 4'b0001, 1'b1);
      do_txn("st1", 4'b0010, 4'b0010, 1'b0);
      do_txn("st2", 4'b0100, 4'b0100, 1'b1);
      do_txn("st3", 4'b1000, 4'b1000, 1'b0);
      chk("st blocks 4", stat_blocks, 4);
      chk("st cmp 2", stat_compressable, 2);
      seq++;
      set_pixels(1'b1);
      res_ready = 1'b0;
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = '0;
      n = 1;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("st stalled blocks", stat_blocks, 4);
      chk("st stalled cmp", stat_compressable, 2);
      res_ready = 1'b1;
      @(negedge clk);
      chk("st blocks 5", stat_blocks, 5);
      chk("st cmp 3", stat_compressable, 3);
      $display("txn stats: blocks=%0d compressable=%0d", stat_blocks, stat_compressable);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
